// File: rtl/main_mem_pkg.sv
// Shared definitions for the main-memory responder: FSM encoding, default
// latencies, MMIO address and a saturating counter helper.
package main_mem_pkg;

   localparam int          CNT_W             = 4;
   localparam int          DEF_READ_LATENCY  = 4;
   localparam int          DEF_WRITE_LATENCY = 2;
   localparam logic [31:0] DEF_OUT_ADDR      = 32'h1000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_t;

   // Which register drives mem_rdata: the array read port or the side register
   // holding MMIO / out-of-range read data.
   typedef enum logic {
      RD_SRC_AUX   = 1'b0,
      RD_SRC_ARRAY = 1'b1
   } rd_src_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/main_mem_array.sv
// Backing store: four independent byte-lane arrays sharing one write address
// and one registered read port, so each lane maps onto a block RAM.
module main_mem_array #(
   parameter int WORDS = 16384,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [WORDS];
         logic [7:0] lane_rdata_reg;

         // Byte-lane write and registered read; read data only moves on re.
         always_ff @(posedge clk) begin
            if (we[gi]) begin
               lane_mem[waddr] <= wdata[gi*8 +: 8];
            end
            if (re) begin
               lane_rdata_reg <= lane_mem[raddr];
            end
         end

         assign rdata[gi*8 +: 8] = lane_rdata_reg;
      end
   endgenerate

endmodule

// File: rtl/main_mem_responder.sv
// Slave end of the picorv32 native memory port: latency-modelled SRAM with
// byte strobes, an output-byte MMIO register and saturating traffic counters.
module main_mem_responder
   import main_mem_pkg::*;
#(
   parameter int          MEM_WORDS     = 16384,
   parameter int          READ_LATENCY  = DEF_READ_LATENCY,
   parameter int          WRITE_LATENCY = DEF_WRITE_LATENCY,
   parameter logic [31:0] OUT_ADDR      = DEF_OUT_ADDR
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic [7:0]  out_byte,
   output logic        out_byte_en,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam int               AW      = $clog2(MEM_WORDS);
   localparam logic [CNT_W-1:0] RD_LAT  = CNT_W'(READ_LATENCY);
   localparam logic [CNT_W-1:0] WR_LAT  = CNT_W'(WRITE_LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [31:0]      WORDS_L = 32'(MEM_WORDS);

   mem_state_t       state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [31:0]      addr_reg;
   logic [31:0]      wdata_reg;
   logic [3:0]       wstrb_reg;
   logic             instr_reg;
   rd_src_t          rd_src_reg;
   logic [31:0]      aux_rdata_reg;

   logic [31:0]      array_rdata;
   logic [3:0]       array_we;
   logic             array_re;

   // Request view: live inputs while IDLE, latched copy otherwise.
   logic [31:0]      eff_addr;
   logic [31:0]      eff_wdata;
   logic [3:0]       eff_wstrb;
   logic [CNT_W-1:0] req_lat;
   logic             eff_is_out;
   logic             eff_in_array;
   logic             enter_resp;

   // The fetch flag and byte-offset bits carry no behaviour in this model.
   logic             unused_bits;
   assign unused_bits = ^{instr_reg, eff_addr[1:0], addr_reg[1:0]};

   // Decode the current transaction and detect the edge that enters RESP.
   always_comb begin
      eff_addr   = addr_reg;
      eff_wdata  = wdata_reg;
      eff_wstrb  = wstrb_reg;
      enter_resp = 1'b0;
      req_lat    = (mem_wstrb == 4'h0) ? RD_LAT : WR_LAT;
      if (state_reg == ST_IDLE) begin
         eff_addr   = mem_addr;
         eff_wdata  = mem_wdata;
         eff_wstrb  = mem_wstrb;
         enter_resp = mem_valid && (req_lat == CNT_ONE);
      end else if (state_reg == ST_WAIT) begin
         enter_resp = (cnt_reg == CNT_ONE);
      end
      eff_is_out   = (eff_addr[31:2] == OUT_ADDR[31:2]);
      eff_in_array = ({2'b00, eff_addr[31:2]} < WORDS_L) && !eff_is_out;
   end

   // Array is read on the edge entering RESP, written on the edge leaving it.
   always_comb begin
      array_re = enter_resp && (eff_wstrb == 4'h0) && eff_in_array;
      array_we = ((state_reg == ST_RESP) && eff_in_array) ? wstrb_reg : 4'h0;
   end

   main_mem_array #(
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (array_we),
      .waddr (addr_reg[AW+1:2]),
      .wdata (wdata_reg),
      .re    (array_re),
      .raddr (eff_addr[AW+1:2]),
      .rdata (array_rdata)
   );

   assign mem_rdata = (rd_src_reg == RD_SRC_ARRAY) ? array_rdata : aux_rdata_reg;

   // Transaction FSM, latency counter, MMIO register and traffic counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         wstrb_reg     <= '0;
         instr_reg     <= 1'b0;
         rd_src_reg    <= RD_SRC_AUX;
         aux_rdata_reg <= '0;
         mem_ready     <= 1'b0;
         out_byte      <= '0;
         out_byte_en   <= 1'b0;
         rd_count      <= '0;
         wr_count      <= '0;
      end else begin
         mem_ready   <= 1'b0;
         out_byte_en <= 1'b0;

         if (enter_resp) begin
            mem_ready <= 1'b1;
            if (eff_wstrb == 4'h0) begin
               rd_src_reg    <= eff_in_array ? RD_SRC_ARRAY : RD_SRC_AUX;
               aux_rdata_reg <= eff_is_out ? {24'h0, out_byte} : 32'h0;
            end else if (eff_is_out && eff_wstrb[0]) begin
               out_byte    <= eff_wdata[7:0];
               out_byte_en <= 1'b1;
            end
         end

         case (state_reg)
            ST_IDLE: begin
               if (mem_valid) begin
                  addr_reg  <= mem_addr;
                  wdata_reg <= mem_wdata;
                  wstrb_reg <= mem_wstrb;
                  instr_reg <= mem_instr;
                  cnt_reg   <= req_lat - CNT_ONE;
                  state_reg <= (req_lat == CNT_ONE) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt_reg <= cnt_reg - CNT_ONE;
               if (cnt_reg == CNT_ONE) begin
                  state_reg <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (wstrb_reg == 4'h0) begin
                  rd_count <= sat_inc(rd_count);
               end else begin
                  wr_count <= sat_inc(wr_count);
               end
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: expected read data is queued when a
// request is driven and compared when mem_ready is observed.
module tb_main_mem_responder;

   localparam int RD_LAT = 4;
   localparam int WR_LAT = 2;

   logic        clk       = 1'b0;
   logic        resetn    = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr  = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [7:0]  out_byte;
   logic        out_byte_en;
   logic [31:0] rd_count;
   logic [31:0] wr_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rdata;
      bit          chk;
      string       tag;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_rd = '0;
   logic [31:0] exp_wr = '0;
   logic        last_oben = 1'b0;
   int          pos[3];

   always #5 clk = ~clk;

   main_mem_responder #(
      .MEM_WORDS     (16384),
      .READ_LATENCY  (RD_LAT),
      .WRITE_LATENCY (WR_LAT),
      .OUT_ADDR      (32'h1000_0000)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .mem_valid   (mem_valid),
      .mem_instr   (mem_instr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .out_byte    (out_byte),
      .out_byte_en (out_byte_en),
      .rd_count    (rd_count),
      .wr_count    (wr_count)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Scoreboard: every mem_ready pulse must match a queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (mem_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_ready", 32'(mem_ready), 32'h0);
         end else begin
            e = exp_q.pop_front();
            if (e.chk) check(e.tag, mem_rdata, e.rdata);
         end
      end
   end

   task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic instr,
                      input logic [31:0] exp_data, input string tag);
      int   n;
      bit   seen;
      int   lat;
      exp_t e;
      lat     = (strb == 4'h0) ? RD_LAT : WR_LAT;
      e.rdata = exp_data;
      e.chk   = (strb == 4'h0);
      e.tag   = tag;
      exp_q.push_back(e);
      @(negedge clk);
      mem_valid = 1'b1;
      mem_instr = instr;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = strb;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (mem_ready) seen = 1'b1;
      end
      last_oben = out_byte_en;
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      mem_wstrb = 4'h0;
      if (!seen) begin
         check({tag, "_timeout"}, 32'h0, 32'h1);
      end else begin
         check({tag, "_latency"}, 32'(n), 32'(lat));
         if (strb == 4'h0) exp_rd++;
         else exp_wr++;
      end
      $display("txn %s addr=%h wstrb=%h wdata=%h rdata=%h cycles=%0d", tag, addr, strb, wdata, mem_rdata, n);
   endtask

   // Counters move on the edge leaving RESP, so sample one cycle later.
   task automatic check_counts(input string tag);
      @(negedge clk);
      check({tag, "_rd_count"}, rd_count, exp_rd);
      check({tag, "_wr_count"}, wr_count, exp_wr);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ready"}, 32'(mem_ready), 32'h0);
      check({tag, "_rdata"}, mem_rdata, 32'h0);
      check({tag, "_out_byte"}, 32'(out_byte), 32'h0);
      check({tag, "_out_en"}, 32'(out_byte_en), 32'h0);
      check({tag, "_rd_count"}, rd_count, 32'h0);
      check({tag, "_wr_count"}, wr_count, 32'h0);
   endtask

   initial begin
      exp_t e;
      int   n;
      int   got;

      repeat (3) @(negedge clk);
      check_reset_state("reset");
      resetn = 1'b1;

      // Full-word write then read back.
      txn(32'h100, 32'hA5A5_1234, 4'hF, 1'b0, 32'h0, "wr_100");
      txn(32'h100, 32'h0, 4'h0, 1'b0, 32'hA5A5_1234, "rd_100");
      check_counts("basic");

      // Single-lane write.
      txn(32'h100, 32'h0000_BB00, 4'b0010, 1'b0, 32'h0, "wr_100_lane1");
      txn(32'h100, 32'h0, 4'h0, 1'b0, 32'hA5A5_BB34, "rd_100_lane1");

      // Output-byte register.
      txn(32'h1000_0000, 32'h0000_0041, 4'h1, 1'b0, 32'h0, "wr_out");
      check("out_en_with_ready", 32'(last_oben), 32'h1);
      check("out_byte", 32'(out_byte), 32'h41);
      @(negedge clk);
      check("out_en_one_cycle", 32'(out_byte_en), 32'h0);
      txn(32'h1000_0000, 32'h0000_9900, 4'h2, 1'b0, 32'h0, "wr_out_lane1");
      check("out_en_lane1", 32'(last_oben), 32'h0);
      check("out_byte_kept", 32'(out_byte), 32'h41);
      txn(32'h1000_0000, 32'h0, 4'h0, 1'b0, 32'h0000_0041, "rd_out");
      check_counts("mmio");

      // Three fetches with mem_valid held high throughout.
      for (int i = 0; i < 3; i++) begin
         e.rdata = 32'hA5A5_BB34;
         e.chk   = 1'b1;
         e.tag   = "fetch";
         exp_q.push_back(e);
      end
      @(negedge clk);
      mem_valid = 1'b1;
      mem_instr = 1'b1;
      mem_addr  = 32'h100;
      mem_wstrb = 4'h0;
      n   = 0;
      got = 0;
      while (got < 3 && n < 60) begin
         @(negedge clk);
         n++;
         if (mem_ready) begin
            pos[got] = n;
            got++;
         end
      end
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      check("fetch_count_seen", 32'(got), 32'd3);
      check("fetch0_pos", 32'(pos[0]), 32'(RD_LAT));
      check("fetch1_pos", 32'(pos[1]), 32'(2 * RD_LAT + 1));
      check("fetch2_pos", 32'(pos[2]), 32'(3 * RD_LAT + 2));
      $display("txn fetch_burst addr=00000100 ready_at=%0d,%0d,%0d", pos[0], pos[1], pos[2]);
      exp_rd += 32'(got);
      check_counts("fetch");

      // Out-of-range accesses; 0x20000 aliases word 0 in the low index bits.
      txn(32'h0, 32'h1122_3344, 4'hF, 1'b0, 32'h0, "wr_0");
      txn(32'h0002_0000, 32'h0, 4'h0, 1'b0, 32'h0, "rd_oor");
      txn(32'h0002_0000, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, "wr_oor");
      txn(32'h0, 32'h0, 4'h0, 1'b0, 32'h1122_3344, "rd_0");
      repeat (3) @(negedge clk);
      check("rdata_held", mem_rdata, 32'h1122_3344);
      check_counts("oor");

      // Reset in the middle of a write.
      txn(32'h200, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0, "wr_200");
      @(negedge clk);
      mem_valid = 1'b1;
      mem_addr  = 32'h200;
      mem_wdata = 32'hCAFE_BABE;
      mem_wstrb = 4'hF;
      @(negedge clk);
      check("abort_no_ready", 32'(mem_ready), 32'h0);
      resetn    = 1'b0;
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      repeat (3) @(negedge clk);
      check_reset_state("abort");
      $display("txn abort_wr_200 addr=00000200 wstrb=f reset during wait");
      resetn = 1'b1;
      exp_rd = '0;
      exp_wr = '0;
      txn(32'h200, 32'h0, 4'h0, 1'b0, 32'h0BAD_F00D, "rd_200_after_abort");
      check_counts("abort");
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
